// File: rtl/input_conditioner.sv
// Per-channel synchroniser, tick-sampled saturating debouncer, registered edge and auto-repeat pulses.
// sync_out lags async_in by SYNC_STAGES clocks; pulses are one clock wide; no backpressure (outputs every cycle).
module input_conditioner #(
  parameter int WIDTH          = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int SAMPLE_CNT_MAX = 25000,
  parameter int PULSE_CNT_MAX  = 150,
  parameter int HOLD_SAMPLES   = 0,
  parameter int REPEAT_SAMPLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] repeat_pulse
);

  localparam int TCW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int DCW = $clog2(PULSE_CNT_MAX + 1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("input_conditioner: SYNC_STAGES must be at least 2");
    end
    if (SAMPLE_CNT_MAX < 1) begin : g_bad_sample_cnt
      $error("input_conditioner: SAMPLE_CNT_MAX must be at least 1");
    end
    if (PULSE_CNT_MAX < 1) begin : g_bad_pulse_cnt
      $error("input_conditioner: PULSE_CNT_MAX must be at least 1");
    end
    if (HOLD_SAMPLES > 0 && REPEAT_SAMPLES > HOLD_SAMPLES) begin : g_bad_repeat
      $error("input_conditioner: REPEAT_SAMPLES may not exceed HOLD_SAMPLES");
    end
  endgenerate

  // Plain flop chain; nothing may sit between stages.
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
  logic           tick;

  always_comb begin
    tick       = (tick_cnt_q == TCW'(SAMPLE_CNT_MAX - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TCW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

  logic [DCW-1:0]   dcnt_q [WIDTH];
  logic [DCW-1:0]   dcnt_d [WIDTH];
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] deb_dly_q;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  // Any agreement, even on a tick, restarts the mismatch count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      dcnt_d[i] = dcnt_q[i];
      if (sync_out[i] == deb_q[i]) begin
        dcnt_d[i] = '0;
      end else if (tick) begin
        if (dcnt_q[i] == DCW'(PULSE_CNT_MAX - 1)) begin
          deb_d[i]  = ~deb_q[i];
          dcnt_d[i] = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + DCW'(1);
        end
      end
    end
  end

  always_comb begin
    rise_d = deb_q & ~deb_dly_q;
    fall_d = ~deb_q & deb_dly_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) dcnt_q[i] <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) dcnt_q[i] <= dcnt_d[i];
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign debounced  = deb_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

  generate
    if (HOLD_SAMPLES > 0) begin : g_repeat
      localparam int HCW    = $clog2(HOLD_SAMPLES + 1);
      localparam int RELOAD = (REPEAT_SAMPLES > 0) ? HOLD_SAMPLES - REPEAT_SAMPLES : HOLD_SAMPLES;

      logic [HCW-1:0]   hold_q [WIDTH];
      logic [HCW-1:0]   hold_d [WIDTH];
      logic [WIDTH-1:0] rep_q, rep_d;

      // Gating on deb_d drops a repeat that lands on the releasing tick,
      // and keeps the rising tick itself out of the hold count.
      always_comb begin
        rep_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
          hold_d[i] = hold_q[i];
          if (!(deb_q[i] && deb_d[i])) begin
            hold_d[i] = '0;
          end else if (tick) begin
            if (hold_q[i] == HCW'(HOLD_SAMPLES - 1)) begin
              rep_d[i]  = 1'b1;
              hold_d[i] = HCW'(RELOAD);
            end else if (hold_q[i] != HCW'(HOLD_SAMPLES)) begin
              hold_d[i] = hold_q[i] + HCW'(1);
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < WIDTH; i++) hold_q[i] <= '0;
          rep_q <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) hold_q[i] <= hold_d[i];
          rep_q <= rep_d;
        end
      end

      assign repeat_pulse = rep_q;
    end else begin : g_no_repeat
      assign repeat_pulse = '0;
    end
  endgenerate

endmodule
